// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: owns the PC, issues one imem request at a time and
// hands each fetched word to decode over valid/ready, restarting on redirects.
module fetch_pc_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc
);

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]      state, state_nxt;
    logic [XLEN-1:0] pc, pc_nxt;
    logic            drop, drop_nxt;
    logic [XLEN-1:0] if_instr_nxt, if_pc_nxt;
    logic [XLEN-1:0] redirect_tgt;
    logic            unused_redirect_lsb;

    assign redirect_tgt        = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_redirect_lsb = &{1'b0, redirect_pc[1:0]};

    // Outputs decode registered state only; no input reaches an output combinationally.
    assign imem_req_valid = (state == S_REQ);
    assign imem_req_addr  = pc;
    assign if_valid       = (state == S_HOLD);

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_REQ;
            pc       <= RESET_PC;
            drop     <= 1'b0;
            if_instr <= '0;
            if_pc    <= '0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            drop     <= drop_nxt;
            if_instr <= if_instr_nxt;
            if_pc    <= if_pc_nxt;
        end
    end

    // Next-state logic; a redirect overrides the PC update in every state.
    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        drop_nxt     = drop;
        if_instr_nxt = if_instr;
        if_pc_nxt    = if_pc;

        case (state)
            S_REQ: begin
                if (imem_req_ready) begin
                    state_nxt = S_WAIT;
                    pc_nxt    = pc + XLEN'(4);
                    if (redirect_valid) begin
                        drop_nxt = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    drop_nxt = 1'b0;
                    if (drop || redirect_valid) begin
                        state_nxt = S_REQ;
                    end else begin
                        state_nxt    = S_HOLD;
                        if_instr_nxt = imem_resp_data;
                        // pc already advanced past the outstanding request
                        if_pc_nxt    = pc - XLEN'(4);
                    end
                end else if (redirect_valid) begin
                    drop_nxt = 1'b1;
                end
            end
            S_HOLD: begin
                if (if_ready || redirect_valid) begin
                    state_nxt = S_REQ;
                end
            end
            default: begin
                state_nxt = S_REQ;
            end
        endcase

        if (redirect_valid) begin
            pc_nxt = redirect_tgt;
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: two instances (RESET_PC 0 and 0xFFFF_FFFC)
// driven by a small in-order memory model with programmable latency.
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    // instance A (RESET_PC = 0)
    logic        imem_req_valid, imem_req_ready, imem_resp_valid;
    logic [31:0] imem_req_addr, imem_resp_data;
    logic        redirect_valid, if_valid, if_ready;
    logic [31:0] redirect_pc, if_instr, if_pc;

    // instance B (RESET_PC = 0xFFFF_FFFC)
    logic        b_req_valid, b_resp_valid, b_if_valid;
    logic [31:0] b_req_addr, b_resp_data, b_if_instr, b_if_pc;

    fetch_pc_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .if_valid(if_valid), .if_ready(if_ready),
        .if_instr(if_instr), .if_pc(if_pc)
    );

    fetch_pc_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst),
        .imem_req_valid(b_req_valid), .imem_req_ready(1'b1),
        .imem_req_addr(b_req_addr), .imem_resp_valid(b_resp_valid),
        .imem_resp_data(b_resp_data), .redirect_valid(1'b0),
        .redirect_pc(32'h0), .if_valid(b_if_valid), .if_ready(1'b1),
        .if_instr(b_if_instr), .if_pc(b_if_pc)
    );

    int          checks = 0;
    int          errors = 0;
    int          lat    = 1;
    bit          pend   = 1'b0;
    int          cnt    = 0;
    logic [31:0] paddr  = '0;
    logic [31:0] last_hs = '0;
    logic [31:0] b_hs_q[$];
    logic [31:0] b_pc_q[$];
    logic [31:0] b_ins_q[$];

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock: sample handshakes before the edge, update memory models 1ns after.
    task automatic step();
        bit          a_hs, b_hs, b_acc;
        logic [31:0] a_addr, b_addr;
        a_hs   = imem_req_valid && imem_req_ready && !rst;
        a_addr = imem_req_addr;
        b_hs   = b_req_valid && !rst;
        b_addr = b_req_addr;
        b_acc  = b_if_valid && !rst;
        if (b_acc) begin
            b_pc_q.push_back(b_if_pc);
            b_ins_q.push_back(b_if_instr);
        end
        @(posedge clk);
        #1;
        imem_resp_valid = 1'b0;
        if (a_hs) begin
            pend    = 1'b1;
            cnt     = lat - 1;
            paddr   = a_addr;
            last_hs = a_addr;
        end
        if (pend) begin
            if (cnt == 0) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = mem(paddr);
                pend            = 1'b0;
            end else begin
                cnt--;
            end
        end
        b_resp_valid = b_hs;
        b_resp_data  = mem(b_addr);
        if (b_hs) b_hs_q.push_back(b_addr);
    endtask

    task automatic set_redirect(input logic [31:0] tgt);
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
    endtask

    initial begin
        rst = 1'b1;
        imem_req_ready = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data = '0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        if_ready = 1'b1;
        b_resp_valid = 1'b0;
        b_resp_data = '0;

        step();
        step();
        check("rst_if_valid", 32'(if_valid), 32'd0);
        check("rst_if_instr", if_instr, 32'd0);
        check("rst_if_pc", if_pc, 32'd0);
        check("rst_req_valid", 32'(imem_req_valid), 32'd1);
        check("rst_req_addr", imem_req_addr, 32'h0);
        check("rst_b_req_addr", b_req_addr, 32'hFFFF_FFFC);
        rst = 1'b0;

        // Straight-line fetch with 1-cycle memory
        for (int i = 0; i < 3; i++) begin
            step();
            check("t1_req_addr", last_hs, 32'(i * 4));
            step();
            check("t1_if_valid", 32'(if_valid), 32'd1);
            check("t1_if_pc", if_pc, 32'(i * 4));
            check("t1_if_instr", if_instr, mem(32'(i * 4)));
            step();
        end

        // Decode back-pressure in HOLD
        if_ready = 1'b0;
        step();
        step();
        check("t2_if_pc", if_pc, 32'h0C);
        for (int i = 0; i < 5; i++) begin
            step();
            check("t2_hold_valid", 32'(if_valid), 32'd1);
            check("t2_hold_pc", if_pc, 32'h0C);
            check("t2_hold_instr", if_instr, mem(32'h0C));
            check("t2_no_req", 32'(imem_req_valid), 32'd0);
        end
        if_ready = 1'b1;
        step();
        check("t2_next_req_valid", 32'(imem_req_valid), 32'd1);
        check("t2_next_req_addr", imem_req_addr, 32'h10);

        // Redirect coincident with the request handshake to 0x10
        set_redirect(32'h0000_0203);
        step();
        redirect_valid = 1'b0;
        check("t4_hs_addr", last_hs, 32'h10);
        step();
        check("t4_dropped", 32'(if_valid), 32'd0);
        check("t4_req_valid", 32'(imem_req_valid), 32'd1);
        check("t4_req_addr", imem_req_addr, 32'h200);
        step();
        step();
        check("t4_tgt_valid", 32'(if_valid), 32'd1);
        check("t4_tgt_pc", if_pc, 32'h200);
        check("t4_tgt_instr", if_instr, mem(32'h200));
        step();

        // Redirect while waiting, response two cycles later
        lat = 3;
        step();
        check("t3_hs_addr", last_hs, 32'h204);
        set_redirect(32'h0000_0103);
        step();
        redirect_valid = 1'b0;
        check("t3_wait_noreq", 32'(imem_req_valid), 32'd0);
        step();
        check("t3_wait_valid", 32'(if_valid), 32'd0);
        lat = 1;
        step();
        check("t3_discard_valid", 32'(if_valid), 32'd0);
        check("t3_req_valid", 32'(imem_req_valid), 32'd1);
        check("t3_req_addr", imem_req_addr, 32'h100);
        step();
        step();
        check("t3_tgt_pc", if_pc, 32'h100);

        // Redirect while holding with decode stalled
        if_ready = 1'b0;
        set_redirect(32'h0000_0040);
        step();
        redirect_valid = 1'b0;
        if_ready = 1'b1;
        check("hold_rd_valid", 32'(if_valid), 32'd0);
        check("hold_rd_addr", imem_req_addr, 32'h40);

        // Redirect and response in the same cycle: no lingering drop
        step();
        set_redirect(32'h0000_0080);
        step();
        redirect_valid = 1'b0;
        check("same_valid", 32'(if_valid), 32'd0);
        check("same_req_addr", imem_req_addr, 32'h80);
        step();
        step();
        check("same_tgt_valid", 32'(if_valid), 32'd1);
        check("same_tgt_pc", if_pc, 32'h80);
        step();

        // Reset in WAIT with the old response arriving after release
        lat = 2;
        step();
        check("t6_hs_addr", last_hs, 32'h84);
        rst = 1'b1;
        step();
        check("t6_rst_valid", 32'(if_valid), 32'd0);
        check("t6_rst_addr", imem_req_addr, 32'h0);
        rst = 1'b0;
        step();
        check("t6_first_req", last_hs, 32'h0);
        check("t6_stale_valid", 32'(if_valid), 32'd0);
        check("t6_wait_noreq", 32'(imem_req_valid), 32'd0);
        step();
        check("t6_wait_valid", 32'(if_valid), 32'd0);
        step();
        check("t6_new_valid", 32'(if_valid), 32'd1);
        check("t6_new_pc", if_pc, 32'h0);
        check("t6_new_instr", if_instr, mem(32'h0));

        // PC wrap on the RESET_PC = 0xFFFF_FFFC instance
        check("wrap_hs_count", 32'(b_hs_q.size() >= 2), 32'd1);
        if (b_hs_q.size() >= 2) begin
            check("wrap_first_req", b_hs_q[0], 32'hFFFF_FFFC);
            check("wrap_second_req", b_hs_q[1], 32'h0000_0000);
        end
        check("wrap_acc_count", 32'(b_pc_q.size() >= 1), 32'd1);
        if (b_pc_q.size() >= 1) begin
            check("wrap_if_pc", b_pc_q[0], 32'hFFFF_FFFC);
            check("wrap_if_instr", b_ins_q[0], mem(32'hFFFF_FFFC));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
